// File: rtl/gray_to_rgb_stream.sv
`default_nettype none
// ============================================================================
//  Module      : gray_to_rgb_stream
//  Description : Streaming single-channel to RGB converter over a fixed
//                IMG_W x IMG_H raster. One output register stage with
//                valid/ready on both sides, frame/line markers, a per-frame
//                colour mode and a completed-frame counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module gray_to_rgb_stream #(
    parameter int PIX_W  = 8,
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    parameter int FCNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PIX_W-1:0]     in_pixel,
    input  logic [1:0]           mode,
    input  logic [PIX_W-1:0]     threshold,
    input  logic [3*PIX_W-1:0]   fg_rgb,
    input  logic [3*PIX_W-1:0]   bg_rgb,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PIX_W-1:0]     out_r,
    output logic [PIX_W-1:0]     out_g,
    output logic [PIX_W-1:0]     out_b,
    output logic                 out_sof,
    output logic                 out_eol,
    output logic                 out_eof,
    output logic                 frame_done,
    output logic [FCNT_W-1:0]    frame_count
);

    // Counter widths; a single-line raster still needs a 1-bit row register.
    localparam int c_COL_W = $clog2(IMG_W);
    localparam int c_ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(IMG_W - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(IMG_H - 1);
    localparam logic [c_COL_W-1:0] c_COL_ONE  = c_COL_W'(1);
    localparam logic [c_ROW_W-1:0] c_ROW_ONE  = c_ROW_W'(1);
    localparam logic [FCNT_W-1:0]  c_FCNT_ONE = FCNT_W'(1);

    localparam logic [1:0] c_MODE_GREY     = 2'd0;
    localparam logic [1:0] c_MODE_INV      = 2'd1;
    localparam logic [1:0] c_MODE_THR      = 2'd2;
    localparam logic [1:0] c_MODE_THR_INV  = 2'd3;

    logic [c_COL_W-1:0]  r_col;
    logic [c_ROW_W-1:0]  r_row;
    logic [1:0]          r_mode;

    logic                r_out_valid;
    logic [PIX_W-1:0]    r_out_r;
    logic [PIX_W-1:0]    r_out_g;
    logic [PIX_W-1:0]    r_out_b;
    logic                r_out_sof;
    logic                r_out_eol;
    logic                r_out_eof;
    logic                r_frame_done;
    logic [FCNT_W-1:0]   r_frame_count;

    logic                w_in_ready;
    logic                w_in_fire;
    logic                w_out_fire;
    logic                w_first;
    logic                w_col_last;
    logic                w_row_last;
    logic [1:0]          w_mode_eff;
    logic                w_hit;
    logic [3*PIX_W-1:0]  w_rgb;

    // The output register can take a new pixel when empty or being drained.
    assign w_in_ready = ~rst & (~r_out_valid | out_ready);
    assign w_in_fire  = in_valid & w_in_ready;
    assign w_out_fire = r_out_valid & out_ready;

    assign w_first    = (r_col == '0) && (r_row == '0);
    assign w_col_last = (r_col == c_COL_LAST);
    assign w_row_last = (r_row == c_ROW_LAST);

    // Pixel (0,0) uses the live mode input, since the latch updates on the
    // same edge that this pixel is accepted.
    assign w_mode_eff = w_first ? mode : r_mode;
    assign w_hit      = (in_pixel >= threshold);

    // Colour mapping for the pixel currently offered on the input.
    always_comb begin
        w_rgb = {3{in_pixel}};
        case (w_mode_eff)
            c_MODE_GREY:    w_rgb = {3{in_pixel}};
            c_MODE_INV:     w_rgb = {3{~in_pixel}};
            c_MODE_THR:     w_rgb = w_hit ? fg_rgb : bg_rgb;
            c_MODE_THR_INV: w_rgb = w_hit ? bg_rgb : fg_rgb;
            default:        w_rgb = {3{in_pixel}};
        endcase
    end

    // Raster position of the next pixel to be accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_in_fire) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : (r_row + c_ROW_ONE);
            end else begin
                r_col <= r_col + c_COL_ONE;
            end
        end
    end

    // Frame mode is captured only when the first pixel of a frame is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode <= '0;
        end else if (w_in_fire && w_first) begin
            r_mode <= mode;
        end
    end

    // Single output register stage; holds while the sink stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_r     <= '0;
            r_out_g     <= '0;
            r_out_b     <= '0;
            r_out_sof   <= 1'b0;
            r_out_eol   <= 1'b0;
            r_out_eof   <= 1'b0;
        end else if (w_in_fire) begin
            r_out_valid <= 1'b1;
            r_out_r     <= w_rgb[3*PIX_W-1:2*PIX_W];
            r_out_g     <= w_rgb[2*PIX_W-1:PIX_W];
            r_out_b     <= w_rgb[PIX_W-1:0];
            r_out_sof   <= w_first;
            r_out_eol   <= w_col_last;
            r_out_eof   <= w_col_last & w_row_last;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Completed-frame pulse and counter, keyed on the end-of-frame beat leaving.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_done  <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_frame_done <= w_out_fire & r_out_eof;
            if (w_out_fire && r_out_eof) begin
                r_frame_count <= r_frame_count + c_FCNT_ONE;
            end
        end
    end

    assign in_ready    = w_in_ready;
    assign out_valid   = r_out_valid;
    assign out_r       = r_out_r;
    assign out_g       = r_out_g;
    assign out_b       = r_out_b;
    assign out_sof     = r_out_sof;
    assign out_eol     = r_out_eol;
    assign out_eof     = r_out_eof;
    assign frame_done  = r_frame_done;
    assign frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_gray_to_rgb_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gray_to_rgb_stream
//  Description : Self-checking bench for gray_to_rgb_stream on a 4x2 raster
//                with a 2-bit frame counter. A pixel-index scoreboard model
//                predicts every output beat, marker and frame count.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gray_to_rgb_stream;

    localparam int W    = 4;
    localparam int H    = 2;
    localparam int NPIX = W * H;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_pixel = '0;
    logic [1:0]  mode = '0;
    logic [7:0]  threshold = '0;
    logic [23:0] fg_rgb = '0;
    logic [23:0] bg_rgb = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_r, out_g, out_b;
    logic        out_sof, out_eol, out_eof;
    logic        frame_done;
    logic [1:0]  frame_count;

    logic [26:0] beat;
    assign beat = {out_r, out_g, out_b, out_sof, out_eol, out_eof};

    gray_to_rgb_stream #(
        .PIX_W  (8),
        .IMG_W  (W),
        .IMG_H  (H),
        .FCNT_W (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pixel    (in_pixel),
        .mode        (mode),
        .threshold   (threshold),
        .fg_rgb      (fg_rgb),
        .bg_rgb      (bg_rgb),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_r       (out_r),
        .out_g       (out_g),
        .out_b       (out_b),
        .out_sof     (out_sof),
        .out_eol     (out_eol),
        .out_eof     (out_eof),
        .frame_done  (frame_done),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [26:0] exp_q[$];
    logic [26:0] obs_log[$];
    int          model_idx = 0;
    logic [1:0]  model_mode = '0;
    logic [1:0]  exp_fc = '0;
    bit          exp_done = 1'b0;
    bit          prev_stall = 1'b0;
    logic [26:0] stall_snap = '0;
    bit          rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Colour rule written directly from the mode table.
    function automatic logic [23:0] model_rgb(input logic [1:0] m, input logic [7:0] p,
                                              input logic [7:0] th, input logic [23:0] fg,
                                              input logic [23:0] bg);
        logic [7:0] ip;
        ip = ~p;
        case (m)
            2'd0:    return {p, p, p};
            2'd1:    return {ip, ip, ip};
            2'd2:    return (p >= th) ? fg : bg;
            default: return (p >= th) ? bg : fg;
        endcase
    endfunction

    task automatic model_reset();
        exp_q.delete();
        model_idx  = 0;
        model_mode = '0;
        exp_fc     = '0;
        exp_done   = 1'b0;
        prev_stall = 1'b0;
    endtask

    // Per-cycle comparison of the DUT against the scoreboard.
    task automatic monitor();
        logic [26:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("frame_done", {31'd0, frame_done}, {31'd0, exp_done});
                check("frame_count", {30'd0, frame_count}, {30'd0, exp_fc});
                exp_done = 1'b0;
                check("in_ready", {31'd0, in_ready}, {31'd0, (!out_valid || out_ready)});
                check("out_valid", {31'd0, out_valid}, {31'd0, (exp_q.size() > 0)});
                if (prev_stall) check("stall_hold", {5'd0, beat}, {5'd0, stall_snap});
                prev_stall = 1'b0;
                if (out_valid && out_ready) begin
                    obs_log.push_back(beat);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("beat", {5'd0, beat}, {5'd0, e});
                        if (e[0]) begin
                            exp_fc   = exp_fc + 2'd1;
                            exp_done = 1'b1;
                        end
                    end
                end else if (out_valid) begin
                    prev_stall = 1'b1;
                    stall_snap = beat;
                end
                if (in_valid && in_ready) begin
                    if (model_idx == 0) model_mode = mode;
                    exp_q.push_back({model_rgb(model_mode, in_pixel, threshold, fg_rgb, bg_rgb),
                                     model_idx == 0, (model_idx % W) == W - 1,
                                     model_idx == NPIX - 1});
                    model_idx = (model_idx + 1) % NPIX;
                end
            end
        end
    endtask

    task automatic send_pixel(input logic [7:0] p);
        bit done = 1'b0;
        in_pixel = p;
        in_valid = 1'b1;
        for (int k = 0; k < 200 && !done; k++) begin
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (in_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: pixel %0h never accepted", p);
        end
    endtask

    task automatic drain();
        bit ok = 1'b0;
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (!out_valid) ok = 1'b1;
        end
        @(posedge clk);
        #1;
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL drain_timeout: out_valid stuck at 1");
        end
    endtask

    task automatic check_log(input string name, input int idx, input logic [26:0] exp);
        if (idx < obs_log.size()) begin
            check(name, {5'd0, obs_log[idx]}, {5'd0, exp});
        end else begin
            tests++;
            fails++;
            $display("FAIL %s: only %0d beats observed, required index %0d", name, obs_log.size(), idx);
        end
    endtask

    initial begin
        fork
            monitor();
        join_none

        // Hand-computed anchors for the colour model.
        check("model_m0", {8'd0, model_rgb(2'd0, 8'h5A, 8'h00, 24'h0, 24'h0)}, 32'h005A5A5A);
        check("model_m1", {8'd0, model_rgb(2'd1, 8'h05, 8'h00, 24'h0, 24'h0)}, 32'h00FAFAFA);
        check("model_m2_lo", {8'd0, model_rgb(2'd2, 8'h7F, 8'h80, 24'hFF0000, 24'h0000FF)}, 32'h000000FF);
        check("model_m2_eq", {8'd0, model_rgb(2'd2, 8'h80, 8'h80, 24'hFF0000, 24'h0000FF)}, 32'h00FF0000);
        check("model_m3_hi", {8'd0, model_rgb(2'd3, 8'hFF, 8'h80, 24'hFF0000, 24'h0000FF)}, 32'h000000FF);

        // Reset state
        #2;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_frame_count", {30'd0, frame_count}, 32'd0);
        check("rst_beat", {5'd0, beat}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        // Grey replicate, full throughput
        obs_log.delete();
        mode = 2'd0;
        for (int i = 0; i < NPIX; i++) send_pixel(8'(i));
        drain();
        check_log("t1_beat0", 0, {24'h000000, 3'b100});
        check_log("t1_beat3", 3, {24'h030303, 3'b010});
        check_log("t1_beat7", 7, {24'h070707, 3'b011});
        check("t1_count", {30'd0, frame_count}, 32'd1);

        // Threshold mode
        obs_log.delete();
        mode = 2'd2; threshold = 8'h80; fg_rgb = 24'hFF0000; bg_rgb = 24'h0000FF;
        send_pixel(8'h7F); send_pixel(8'h80); send_pixel(8'hFF); send_pixel(8'h00);
        for (int i = 0; i < 4; i++) send_pixel(8'h10);
        drain();
        check_log("t2_b0", 0, {24'h0000FF, 3'b100});
        check_log("t2_b1", 1, {24'hFF0000, 3'b000});
        check_log("t2_b2", 2, {24'hFF0000, 3'b000});
        check_log("t2_b3", 3, {24'h0000FF, 3'b010});
        check("t2_count", {30'd0, frame_count}, 32'd2);

        // Threshold inverted
        obs_log.delete();
        mode = 2'd3;
        send_pixel(8'h7F); send_pixel(8'h80); send_pixel(8'hFF); send_pixel(8'h00);
        for (int i = 0; i < 4; i++) send_pixel(8'h10);
        drain();
        check_log("t3_b0", 0, {24'hFF0000, 3'b100});
        check_log("t3_b1", 1, {24'h0000FF, 3'b000});
        check_log("t3_b2", 2, {24'h0000FF, 3'b000});
        check_log("t3_b3", 3, {24'hFF0000, 3'b010});
        check("t3_count", {30'd0, frame_count}, 32'd3);

        // Backpressure mid-frame with input pending
        obs_log.delete();
        mode = 2'd0;
        send_pixel(8'h20); send_pixel(8'h21); send_pixel(8'h22);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pixel  = 8'h23;
        repeat (5) begin
            @(negedge clk);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        for (int i = 3; i < NPIX; i++) send_pixel(8'(8'h20 + i));
        drain();
        check("bp_len", obs_log.size(), 32'd8);
        check_log("bp_b2", 2, {24'h222222, 3'b000});
        check_log("bp_b3", 3, {24'h232323, 3'b010});
        check_log("bp_b4", 4, {24'h242424, 3'b000});
        check("bp_count", {30'd0, frame_count}, 32'd0);

        // Mode change mid-frame takes effect at next frame
        obs_log.delete();
        mode = 2'd0;
        send_pixel(8'h10); send_pixel(8'h11);
        mode = 2'd1;
        for (int i = 2; i < NPIX; i++) send_pixel(8'(8'h10 + i));
        send_pixel(8'h05);
        for (int i = 1; i < NPIX; i++) send_pixel(8'(i));
        drain();
        check_log("ms_b2", 2, {24'h121212, 3'b000});
        check_log("ms_b7", 7, {24'h171717, 3'b011});
        check_log("ms_b8", 8, {24'hFAFAFA, 3'b100});
        check("ms_count", {30'd0, frame_count}, 32'd2);

        // Asynchronous reset mid-frame with a beat pending
        mode = 2'd0;
        send_pixel(8'h31); send_pixel(8'h32); send_pixel(8'h33);
        check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #1 rst = 1'b1;
        model_reset();
        #1;
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        check("arst_beat", {5'd0, beat}, 32'd0);
        check("arst_count", {30'd0, frame_count}, 32'd0);
        check("arst_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        obs_log.delete();
        mode = 2'd1;
        for (int i = 0; i < NPIX; i++) send_pixel(8'(8'h40 + i));
        drain();
        check_log("post_rst_b0", 0, {24'hBFBFBF, 3'b100});
        check("post_rst_count", {30'd0, frame_count}, 32'd1);

        // Four more randomized frames: five since reset, count wraps to 1
        rand_ready = 1'b1;
        for (int f = 0; f < 4 * NPIX; f++) begin
            mode      = 2'($urandom_range(0, 3));
            threshold = 8'($urandom);
            fg_rgb    = 24'($urandom);
            bg_rgb    = 24'($urandom);
            send_pixel(8'($urandom));
            repeat ($urandom_range(0, 2)) begin
                out_ready = ($urandom_range(0, 3) != 0);
                @(posedge clk);
                #1;
            end
        end
        drain();
        check("rand_count", {30'd0, frame_count}, 32'd1);
        check("rand_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/gray_to_rgb_stream.md
Name: gray_to_rgb_stream

Overview:
- Parametrised streaming converter: single-channel pixels in, RGB pixels out, over a fixed IMG_W x IMG_H raster.
- Successor to the fixed 256x256 grey-to-RGB path. Adds:
  - valid/ready backpressure on both sides;
  - frame and line markers;
  - per-frame selectable colour mode (grey replicate, invert, threshold to foreground/background colours);
  - a frame counter.
- Sits between the pixel source (decoder/sensor stub) and the RGB sink (image writer).

Parameters:
- PIX_W, 8, bits per channel (input pixel and each output channel).
- IMG_W, 256, pixels per line; must be >= 2.
- IMG_H, 256, lines per frame; must be >= 1.
- FCNT_W, 16, frame_count width.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block accepts input this cycle.
- in_pixel  in  PIX_W  input pixel.
- mode  in  2  0=grey replicate, 1=grey inverted, 2=threshold, 3=threshold inverted.
- threshold  in  PIX_W  threshold level for modes 2/3.
- fg_rgb  in  3*PIX_W  foreground colour {R,G,B}, R in MSBs.
- bg_rgb  in  3*PIX_W  background colour {R,G,B}.
- out_valid  out  1  output beat valid.
- out_ready  in  1  sink accepts output.
- out_r, out_g, out_b  out  PIX_W each  output channels.
- out_sof  out  1  beat is pixel (0,0) of the frame.
- out_eol  out  1  beat is the last pixel of a line (col = IMG_W-1).
- out_eof  out  1  beat is the last pixel of the frame.
- frame_done  out  1  one-cycle pulse per completed output frame.
- frame_count  out  FCNT_W  number of completed output frames.

Behaviour:
- Reset (async, any time, including mid-frame):
  - out_valid, out_r/g/b, out_sof/eol/eof, frame_done = 0; frame_count = 0.
  - col/row counters = 0; latched mode = 0.
  - in_ready = 0 while rst is high. Any partial frame is discarded; the first accepted pixel after reset is (0,0).
- Handshake:
  - Input transfer when in_valid & in_ready. Output transfer when out_valid & out_ready.
  - in_ready = !out_valid | out_ready (combinational, single output register stage).
  - Latency 1 cycle: a pixel accepted at edge N is presented at out_* after edge N. Full throughput (1 pixel/cycle) while out_ready = 1.
  - While out_valid=1 & out_ready=0, all out_* hold stable and in_ready=0.
  - When out_valid=1, out_ready=1 and no input is accepted: out_valid drops to 0 on the next edge.
- Counters:
  - col advances on each input transfer.
  - At col=IMG_W-1, col wraps to 0 and row increments.
  - At col=IMG_W-1 & row=IMG_H-1, both wrap to 0 and the next frame begins. No stalling at the frame end.
- Markers (registered with the pixel):
  - out_sof = (col==0 & row==0).
  - out_eol = (col==IMG_W-1).
  - out_eof = (col==IMG_W-1 & row==IMG_H-1).
- Mode latching:
  - mode is sampled on the input transfer of pixel (0,0) and applies to that whole frame.
  - Changes to mode mid-frame are ignored until the next frame start.
  - threshold, fg_rgb and bg_rgb are sampled per pixel.
- Colour mapping (p = in_pixel):
  - Mode 0: R=G=B=p.
  - Mode 1: R=G=B=~p (bitwise, PIX_W bits).
  - Mode 2: p >= threshold ? fg_rgb : bg_rgb (unsigned compare).
  - Mode 3: p >= threshold ? bg_rgb : fg_rgb.
- Frame completion:
  - frame_done pulses for the one cycle after the edge at which an out_eof beat transfers.
  - frame_count increments on that same edge and wraps modulo 2^FCNT_W.

Test Plan:
- IMG_W=4, IMG_H=2, mode=0, out_ready=1, feed pixels 0x00..0x07 back-to-back:
  - outputs R=G=B=0x00..0x07, one cycle after each input;
  - out_sof on beat 0 only; out_eol on beats 3 and 7; out_eof on beat 7;
  - frame_done pulses once; frame_count=1.
- Mode 2, threshold=0x80, fg=0xFF0000, bg=0x0000FF, pixels 0x7F, 0x80, 0xFF, 0x00:
  - outputs 0x0000FF, 0xFF0000, 0xFF0000, 0x0000FF.
  - Repeat with mode 3: outputs swap.
- Backpressure: hold out_ready=0 for 5 cycles mid-frame with in_valid=1:
  - out_* stable, in_ready=0;
  - no pixel lost or duplicated; column sequence continues correctly on release.
- Mode switched 0->1 at pixel 2 of a frame:
  - remainder of the frame stays mode 0;
  - the next frame's pixel 0x05 outputs 0xFA on all channels.
- Run 3 back-to-back frames:
  - markers repeat each frame; frame_count = 1, 2, 3.
  - With FCNT_W=2, 5 frames -> frame_count = 1.
- Assert rst mid-frame (after 3 pixels) while out_valid=1:
  - outputs clear immediately (asynchronously); frame_count=0;
  - the next accepted pixel carries out_sof=1.
